seq_divider: RTL and testbench

Sequential restoring divider, the inverse datapath of the shift-add sequential multiplier in the arithmetic library. It accepts an unsigned W-bit dividend and divisor on a start handshake and iterates one quotient bit per clock. It returns the W-bit quotient and remainder with a Done flag. It sits beside the multiplier as a low-area arithmetic unit for controller datapaths.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 37 +++
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider.
//   div_state_t   - FSM state encoding (IDLE, CALC, FINISH)
//   DIV_DEFAULT_W - default operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    localparam int DIV_DEFAULT_W = 8;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Shifts {R,Q} left by one, trial-subtracts D from the shifted R and sets
// the new quotient LSB from whether the subtraction stayed non-negative.
// Ports:
//   i_r [W:0]   partial remainder
//   i_q [W-1:0] dividend/quotient shift register
//   i_d [W-1:0] divisor
//   o_r [W:0]   next partial remainder
//   o_q [W-1:0] next quotient shift register
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   i_r,
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_d,
    output logic [W:0]   o_r,
    output logic [W-1:0] o_q
);

    logic [W:0]   w_rs;
    logic [W+1:0] w_diff;
    logic         w_neg;
    logic         w_unused_rtop;

    // R stays below D between steps, so its top bit is always 0 and the
    // shift simply drops it.
    assign w_unused_rtop = i_r[W];

    assign w_rs   = {i_r[W-1:0], i_q[W-1]};
    // One extra bit so the borrow shows up as a sign bit.
    assign w_diff = {1'b0, w_rs} - {2'b00, i_d};
    assign w_neg  = w_diff[W+1];

    assign o_r = w_neg ? w_rs : w_diff[W:0];
    assign o_q = {i_q[W-2:0], ~w_neg};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned W-bit sequential restoring divider, one quotient
// bit per clock. W+1 cycles from accept to Done (1 cycle for divide by 0).
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start                 request, sampled only while idle
//   Dividend, Divisor     operands, captured on the accepting edge
//   Quotient, Remainder   registered results, held until the next result
//   Done                  result valid until the next accepted start
//   Busy                  operation in progress
//   DivByZero             last result came from a zero divisor
module seq_divider
    import div_pkg::*;
#(
    parameter int W = DIV_DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] Dividend,
    input  logic [W-1:0] Divisor,
    output logic [W-1:0] Quotient,
    output logic [W-1:0] Remainder,
    output logic         Done,
    output logic         Busy,
    output logic         DivByZero
);

    localparam int CW = $clog2(W + 1);

    div_state_t   r_state, w_next;
    logic [W:0]   r_r;
    logic [W-1:0] r_q, r_d;
    logic [CW-1:0] r_cnt;
    logic         r_dz;
    logic [W-1:0] r_quot, r_rem;
    logic         r_done, r_dbz;
    logic [W:0]   w_r_nxt;
    logic [W-1:0] w_q_nxt;

    div_step #(.W(W)) u_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_r_nxt),
        .o_q (w_q_nxt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (Divisor == '0) ? FINISH : CALC;
            // cnt==1 here means this edge performs the last of W steps
            CALC:    if (r_cnt == CW'(1)) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_r    <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_dz   <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // r_q doubles as the latched dividend for the
                        // divide-by-zero result, since no steps run then.
                        r_r    <= '0;
                        r_q    <= Dividend;
                        r_d    <= Divisor;
                        r_cnt  <= CW'(W);
                        r_dz   <= (Divisor == '0);
                        r_done <= 1'b0;
                        r_dbz  <= 1'b0;
                    end
                end
                CALC: begin
                    r_r   <= w_r_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                FINISH: begin
                    if (r_dz) begin
                        r_quot <= '1;
                        r_rem  <= r_q;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_quot <= r_q;
                        r_rem  <= r_r[W-1:0];
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Quotient  = r_quot;
    assign Remainder = r_rem;
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider at W=8 plus a W=16
// instance for wide operands.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start8, start16;
    logic [7:0]  dvd8, dvs8, q8, r8;
    logic [15:0] dvd16, dvs16, q16, r16;
    logic        done8, busy8, dz8, done16, busy16, dz16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8),
        .Dividend(dvd8), .Divisor(dvs8),
        .Quotient(q8), .Remainder(r8),
        .Done(done8), .Busy(busy8), .DivByZero(dz8)
    );

    seq_divider #(.W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16),
        .Dividend(dvd16), .Divisor(dvs16),
        .Quotient(q16), .Remainder(r16),
        .Done(done16), .Busy(busy16), .DivByZero(dz16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done8 && n < 40);
    endtask

    // Accept one W=8 operation and check latency and results.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input int elat);
        int n;
        dvd8 = a; dvs8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk({tag, "_busy_acc"}, busy8, 1);
        chk({tag, "_done_clr"}, done8, 0);
        chk({tag, "_dz_clr"}, dz8, 0);
        wait_done8(n);
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_q"}, q8, eq);
        chk({tag, "_r"}, r8, er);
        chk({tag, "_dz"}, dz8, edz);
        chk({tag, "_busy"}, busy8, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int n, last, pulses;
        logic [7:0]  a8, b8;
        logic [15:0] a16, b16;

        reset_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
        dvd8 = '0; dvs8 = '0; dvd16 = '0; dvs16 = '0;
        tick(); tick();
        chk("rst_q", q8, 0);
        chk("rst_r", r8, 0);
        chk("rst_done", done8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_dz", dz8, 0);
        reset_n = 1'b1;
        tick();

        run8("d100_7",  8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9);
        run8("d255_1",  8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9);
        run8("d5_9",    8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9);
        run8("d0_3",    8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 9);
        run8("d255_255",8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9);
        run8("d37_0",   8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 1);
        run8("d12_4",   8'd12,  8'd4,   8'd3,   8'd0,  1'b0, 9);

        // Start ignored while busy, operands not re-sampled.
        dvd8 = 8'd200; dvs8 = 8'd3; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        dvd8 = 8'd9; dvs8 = 8'd2; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(n);
        chk("busy_start_lat", n + 4, 9);
        chk("busy_start_q", q8, 66);
        chk("busy_start_r", r8, 2);
        tick(); tick(); tick();
        chk("no_relaunch_busy", busy8, 0);
        chk("no_relaunch_done", done8, 1);
        chk("no_relaunch_q", q8, 66);

        // Reset mid-operation aborts with nothing written.
        dvd8 = 8'd100; dvs8 = 8'd7; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_q", q8, 0);
        chk("midrst_r", r8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_busy", busy8, 0);
        chk("midrst_dz", dz8, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("midrst_no_done", done8, 0);
        chk("midrst_idle", busy8, 0);
        run8("d50_6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 9);

        // Start held high: one Done cycle every W+2 = 10 cycles.
        dvd8 = 8'd77; dvs8 = 8'd10; start8 = 1'b1;
        last = -1; pulses = 0;
        for (int c = 0; c < 45; c++) begin
            tick();
            if (done8) begin
                pulses++;
                chk("hold_q", q8, 7);
                chk("hold_r", r8, 7);
                if (last >= 0) chk("hold_period", c - last, 10);
                last = c;
            end
        end
        start8 = 1'b0;
        chk("hold_pulses", pulses, 4);
        for (int i = 0; i < 12; i++) tick();

        // Random W=8 against a reference quotient/remainder.
        for (int i = 0; i < 8; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(1, 255));
            run8("rnd8", a8, b8, a8 / b8, a8 % b8, 1'b0, 9);
        end

        // Random W=16: reconstruct the dividend from the results.
        for (int i = 0; i < 8; i++) begin
            a16 = 16'($urandom_range(0, 65535));
            b16 = 16'($urandom_range(1, 65535));
            dvd16 = a16; dvs16 = b16; start16 = 1'b1;
            tick();
            start16 = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
            end while (!done16 && n < 60);
            chk("rnd16_lat", n, 17);
            chk("rnd16_ident", 32'(q16) * 32'(b16) + 32'(r16), 32'(a16));
            chk("rnd16_rem_lt", 32'(r16 < b16), 1);
            chk("rnd16_dz", dz16, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
